// File: rtl/jesd204b_link_seq.sv
// rtl/jesd204b_link_seq.sv - JESD204B 4-lane link bring-up and recovery sequencer
// Sequences GT resets, waits for PHY/sync, qualifies stability and retries on faults.
module jesd204b_link_seq #(
   parameter int unsigned SYS_RST_CYC  = 10000,
   parameter int unsigned GAP_CYC      = 90000,
   parameter int unsigned DATA_RST_CYC = 10000,
   parameter int unsigned DONE_TMO     = 1000000,
   parameter int unsigned SYNC_TMO     = 1000000,
   parameter int unsigned STABLE_CYC   = 100000,
   parameter logic [7:0]  MAX_RETRY    = 8'd8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       pll_locked,
   input  logic       gt_powergood,
   input  logic       tx_reset_done,
   input  logic       rx_reset_done,
   input  logic       sync_b,
   input  logic       link_err,
   output logic       gt_sys_reset,
   output logic       gt_data_reset,
   output logic       link_reset_b,
   output logic       phy_ready,
   output logic       fail,
   output logic [7:0] retry_cnt,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SYS_RST   = 3'd1,
      GAP       = 3'd2,
      DATA_RST  = 3'd3,
      DONE_WAIT = 3'd4,
      SYNC_WAIT = 3'd5,
      RUN       = 3'd6,
      FAILED    = 3'd7
   } state_t;

   // Timed phases leave on the last cycle of their window, so compare against N-1.
   localparam logic [23:0] SYS_LAST    = 24'(SYS_RST_CYC - 1);
   localparam logic [23:0] GAP_LAST    = 24'(GAP_CYC - 1);
   localparam logic [23:0] DATA_LAST   = 24'(DATA_RST_CYC - 1);
   localparam logic [23:0] DONE_LAST   = 24'(DONE_TMO - 1);
   localparam logic [23:0] SYNC_LAST   = 24'(SYNC_TMO - 1);
   localparam logic [23:0] STABLE_SAT  = 24'(STABLE_CYC);

   state_t      cur;
   state_t      nxt;
   logic [23:0] timer;
   logic [23:0] timer_nxt;
   logic [7:0]  retry_nxt;
   logic        do_retry;

   always_comb begin
      nxt       = cur;
      timer_nxt = timer + 24'd1;
      retry_nxt = retry_cnt;
      do_retry  = 1'b0;
      if (!enable) begin
         nxt       = IDLE;
         retry_nxt = 8'd0;
      end else if (!pll_locked && cur != FAILED) begin
         nxt = IDLE;
      end else begin
         case (cur)
            IDLE:      if (gt_powergood) nxt = SYS_RST;
            SYS_RST:   if (timer == SYS_LAST) nxt = GAP;
            GAP:       if (timer == GAP_LAST) nxt = DATA_RST;
            DATA_RST:  if (timer == DATA_LAST) nxt = DONE_WAIT;
            DONE_WAIT: begin
               // Success is tested first so it wins over a coincident timeout.
               if (tx_reset_done && rx_reset_done && gt_powergood) nxt = SYNC_WAIT;
               else if (timer == DONE_LAST) do_retry = 1'b1;
            end
            SYNC_WAIT: begin
               if (sync_b) nxt = RUN;
               else if (timer == SYNC_LAST) do_retry = 1'b1;
            end
            RUN: begin
               if (!sync_b || link_err || !gt_powergood) do_retry = 1'b1;
               else if (timer == STABLE_SAT) timer_nxt = timer;
            end
            FAILED:    nxt = FAILED;
            default:   nxt = IDLE;
         endcase
      end
      if (do_retry) begin
         if (retry_cnt >= MAX_RETRY) begin
            nxt = FAILED;
         end else begin
            nxt = SYS_RST;
            if (retry_cnt != 8'hFF) retry_nxt = retry_cnt + 8'd1;
         end
      end
      if (nxt != cur || nxt == IDLE || nxt == FAILED) timer_nxt = 24'd0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur           <= IDLE;
         timer         <= 24'd0;
         retry_cnt     <= 8'd0;
         gt_sys_reset  <= 1'b0;
         gt_data_reset <= 1'b0;
         link_reset_b  <= 1'b0;
         phy_ready     <= 1'b0;
         fail          <= 1'b0;
      end else begin
         cur           <= nxt;
         timer         <= timer_nxt;
         retry_cnt     <= retry_nxt;
         // Outputs decode the state being entered so they move with the state register.
         gt_sys_reset  <= (nxt == SYS_RST);
         gt_data_reset <= (nxt == DATA_RST);
         link_reset_b  <= (nxt == SYNC_WAIT) || (nxt == RUN);
         phy_ready     <= (nxt == RUN) && (timer_nxt == STABLE_SAT);
         fail          <= (nxt == FAILED);
      end
   end

   assign state = cur;

endmodule

// File: tb/tb_jesd204b_link_seq.sv
// tb/tb_jesd204b_link_seq.sv - bench for jesd204b_link_seq
// Directed bring-up/recovery scenarios plus random stimulus against a phase/age model.
module tb_jesd204b_link_seq;

   localparam int SYS_C    = 4;
   localparam int GAP_C    = 3;
   localparam int DATA_C   = 4;
   localparam int DONE_C   = 16;
   localparam int SYNC_C   = 12;
   localparam int STABLE_C = 8;
   localparam int MAXR     = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       pll_locked = 1'b0;
   logic       gt_powergood = 1'b0;
   logic       tx_reset_done = 1'b0;
   logic       rx_reset_done = 1'b0;
   logic       sync_b = 1'b0;
   logic       link_err = 1'b0;
   logic       gt_sys_reset;
   logic       gt_data_reset;
   logic       link_reset_b;
   logic       phy_ready;
   logic       fail;
   logic [7:0] retry_cnt;
   logic [2:0] state;

   int errors = 0;
   int checks = 0;

   int m_phase = 0;
   int m_age = 0;
   int m_retry = 0;
   int window [8];

   jesd204b_link_seq #(
      .SYS_RST_CYC (SYS_C),
      .GAP_CYC     (GAP_C),
      .DATA_RST_CYC(DATA_C),
      .DONE_TMO    (DONE_C),
      .SYNC_TMO    (SYNC_C),
      .STABLE_CYC  (STABLE_C),
      .MAX_RETRY   (8'(MAXR))
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .pll_locked   (pll_locked),
      .gt_powergood (gt_powergood),
      .tx_reset_done(tx_reset_done),
      .rx_reset_done(rx_reset_done),
      .sync_b       (sync_b),
      .link_err     (link_err),
      .gt_sys_reset (gt_sys_reset),
      .gt_data_reset(gt_data_reset),
      .link_reset_b (link_reset_b),
      .phy_ready    (phy_ready),
      .fail         (fail),
      .retry_cnt    (retry_cnt),
      .state        (state)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Model: a phase number plus cycles spent in it; windows from the parameter table.
   task automatic model_edge();
      int  next;
      bit  retry_req;
      if (reset) begin
         m_phase = 0;
         m_age   = 0;
         m_retry = 0;
         return;
      end
      next      = m_phase;
      retry_req = 0;
      if (!enable) begin
         next    = 0;
         m_retry = 0;
      end else if (!pll_locked && m_phase != 7) begin
         next = 0;
      end else if (m_phase == 0) begin
         next = gt_powergood ? 1 : 0;
      end else if (m_phase >= 1 && m_phase <= 3) begin
         if (m_age + 1 == window[m_phase]) next = m_phase + 1;
      end else if (m_phase == 4 || m_phase == 5) begin
         if (m_phase == 4 ? (tx_reset_done && rx_reset_done && gt_powergood) : sync_b)
            next = m_phase + 1;
         else if (m_age + 1 == window[m_phase])
            retry_req = 1;
      end else if (m_phase == 6) begin
         if (!sync_b || link_err || !gt_powergood) retry_req = 1;
      end
      if (retry_req) begin
         if (m_retry == MAXR) next = 7;
         else begin
            next = 1;
            m_retry++;
         end
      end
      if (next != m_phase) m_age = 0;
      else if (m_phase != 6 || m_age < STABLE_C) m_age++;
      m_phase = next;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         model_edge();
         @(posedge clk);
         #1;
         chk("state", int'(state), m_phase);
         chk("gt_sys_reset", int'(gt_sys_reset), int'(m_phase == 1));
         chk("gt_data_reset", int'(gt_data_reset), int'(m_phase == 3));
         chk("link_reset_b", int'(link_reset_b), int'(m_phase == 5 || m_phase == 6));
         chk("phy_ready", int'(phy_ready), int'(m_phase == 6 && m_age == STABLE_C));
         chk("fail", int'(fail), int'(m_phase == 7));
         chk("retry_cnt", int'(retry_cnt), m_retry);
      end
   endtask

   task automatic wait_phase(input int p, input int budget);
      int n = 0;
      while (m_phase != p && n < budget) begin
         step(1);
         n++;
      end
      chk("reach_state", int'(state), p);
   endtask

   initial begin
      window[1] = SYS_C;
      window[2] = GAP_C;
      window[3] = DATA_C;
      window[4] = DONE_C;
      window[5] = SYNC_C;

      // Reset state
      step(2);
      chk("rst_state", int'(state), 0);
      chk("rst_link_reset_b", int'(link_reset_b), 0);
      reset = 1'b0;

      // T1 nominal bring-up
      pll_locked = 1; gt_powergood = 1; enable = 1;
      step(1);
      chk("t1_sys_rise", int'(gt_sys_reset), 1);
      step(3);
      chk("t1_sys_hold", int'(gt_sys_reset), 1);
      step(1);
      chk("t1_sys_fall", int'(gt_sys_reset), 0);
      chk("t1_gap_state", int'(state), 2);
      step(3);
      chk("t1_data_rise", int'(gt_data_reset), 1);
      step(3);
      chk("t1_data_hold", int'(gt_data_reset), 1);
      step(1);
      chk("t1_data_fall", int'(gt_data_reset), 0);
      chk("t1_done_wait", int'(state), 4);
      tx_reset_done = 1; rx_reset_done = 1;
      step(1);
      chk("t1_link_release", int'(link_reset_b), 1);
      sync_b = 1;
      step(1);
      chk("t1_run", int'(state), 6);
      step(7);
      chk("t1_ready_early", int'(phy_ready), 0);
      step(1);
      chk("t1_ready", int'(phy_ready), 1);

      // T2 DONE_WAIT timeout
      reset = 1; step(1); reset = 0;
      rx_reset_done = 0; sync_b = 0;
      step(12);
      chk("t2_done_wait", int'(state), 4);
      step(15);
      chk("t2_still_waiting", int'(state), 4);
      step(1);
      chk("t2_retry_cnt", int'(retry_cnt), 1);
      chk("t2_sys_again", int'(gt_sys_reset), 1);

      // T3 sync timeouts exhaust retries
      rx_reset_done = 1;
      wait_phase(7, 200);
      chk("t3_fail", int'(fail), 1);
      chk("t3_retry_cnt", int'(retry_cnt), MAXR);
      step(5);
      chk("t3_parked", int'(state), 7);
      enable = 0;
      step(1);
      chk("t3_abort_state", int'(state), 0);
      chk("t3_abort_fail", int'(fail), 0);
      chk("t3_abort_retry", int'(retry_cnt), 0);

      // T4 link error in RUN
      enable = 1; sync_b = 1;
      wait_phase(6, 100);
      step(STABLE_C);
      chk("t4_ready", int'(phy_ready), 1);
      link_err = 1;
      step(1);
      link_err = 0;
      chk("t4_ready_drop", int'(phy_ready), 0);
      chk("t4_link_drop", int'(link_reset_b), 0);
      chk("t4_retry", int'(retry_cnt), 1);
      chk("t4_state", int'(state), 1);

      // T5 PLL loss mid DATA_RST
      wait_phase(3, 50);
      step(1);
      pll_locked = 0;
      step(1);
      chk("t5_state", int'(state), 0);
      chk("t5_data_rst", int'(gt_data_reset), 0);
      chk("t5_retry", int'(retry_cnt), 1);
      pll_locked = 1;
      step(1);
      chk("t5_restart", int'(state), 1);

      // T6 reset while in RUN
      wait_phase(6, 100);
      reset = 1;
      step(1);
      reset = 0;
      chk("t6_state", int'(state), 0);
      chk("t6_outputs", int'({gt_sys_reset, gt_data_reset, link_reset_b, phy_ready, fail}), 0);
      chk("t6_retry", int'(retry_cnt), 0);
      step(1);
      chk("t6_resume", int'(state), 1);

      // Random stimulus
      for (int i = 0; i < 4000; i++) begin
         reset         = ($urandom_range(0, 999) == 0);
         enable        = ($urandom_range(0, 299) != 0);
         pll_locked    = ($urandom_range(0, 199) != 0);
         gt_powergood  = ($urandom_range(0, 149) != 0);
         tx_reset_done = ($urandom_range(0, 3) != 0);
         rx_reset_done = ($urandom_range(0, 3) != 0);
         sync_b        = ($urandom_range(0, 7) != 0);
         link_err      = ($urandom_range(0, 63) == 0);
         step(1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
